// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master: datapath side (drives ID/EX hazard info); slave: the controller.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             branch_taken;
  logic             jump;
  logic             mem_busy;
  logic             halt_req;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_mem_read, ex_rd, branch_taken, jump,
    output mem_busy, halt_req,
    input  pc_write, if_id_write, if_id_flush,
    input  id_ex_bubble, pipe_freeze, halted,
    input  timeout_err, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_mem_read, ex_rd, branch_taken, jump,
    input  mem_busy, halt_req,
    output pc_write, if_id_write, if_id_flush,
    output id_ex_bubble, pipe_freeze, halted,
    output timeout_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: load-use stall, branch flush, mem wait, init, halt.
// Ports: clk, rst (async, active-high), hz (slave side of the bundle).
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int IC_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IC_W-1:0] INIT_LAST =
    IC_W'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
  localparam logic [WT_W-1:0] WAIT_LAST =
    WT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_WAIT,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [IC_W-1:0]  init_q, init_d;
  logic [WT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             tmo_q, tmo_d;

  logic load_use;
  logic init_last;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
    ((hz.id_uses_rs && (hz.ex_rd == hz.id_rs)) ||
     (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

  assign init_last = (INIT_CYCLES == 0) || (init_q == INIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      init_q  <= '0;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    init_d          = init_q;
    wait_d          = wait_q;
    stall_d         = stall_q;
    flush_d         = flush_q;
    tmo_d           = tmo_q;
    hz.pc_write     = 1'b0;
    hz.if_id_write  = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    hz.pipe_freeze  = 1'b0;
    hz.halted       = 1'b0;
    unique case (state_q)
      S_INIT: begin
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b1;
        hz.id_ex_bubble = 1'b1;
        init_d          = init_q + 1'b1;
        if (init_last) state_d = S_RUN;
      end
      S_RUN, S_WAIT: begin
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
        wait_d         = '0;
        state_d        = S_RUN;
        priority case (1'b1)
          hz.halt_req: begin
            hz.pc_write    = 1'b0;
            hz.if_id_flush = 1'b1;
            state_d        = S_HALT;
          end
          hz.mem_busy: begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.pipe_freeze = 1'b1;
            if (~&stall_q) stall_d = stall_q + 1'b1;
            // Timeout fires on the TIMEOUT-th consecutive busy cycle.
            if (wait_q == WAIT_LAST) begin
              tmo_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              wait_d  = wait_q + 1'b1;
              state_d = S_WAIT;
            end
          end
          // Stall wins over redirect; the branch is seen again next cycle.
          load_use: begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
            if (~&stall_q) stall_d = stall_q + 1'b1;
          end
          hz.branch_taken || hz.jump: begin
            hz.if_id_flush = 1'b1;
            if (~&flush_q) flush_d = flush_q + 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT: begin
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b1;
        hz.id_ex_bubble = 1'b1;
        hz.halted       = 1'b1;
      end
    endcase
  end

  assign hz.timeout_err  = tmo_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two configurations, directed steps.
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_INIT = 7'b0111000;
  localparam logic [6:0] C_RUN  = 7'b1100000;
  localparam logic [6:0] C_LU   = 7'b0001000;
  localparam logic [6:0] C_FL   = 7'b1110000;
  localparam logic [6:0] C_MB   = 7'b0000100;
  localparam logic [6:0] C_HR   = 7'b0110000;
  localparam logic [6:0] C_HLT  = 7'b0111010;
  localparam logic [6:0] C_TMO  = 7'b0111011;

  typedef struct {
    bit         sel;
    logic [6:0] ctrl;
    int         stall;
    int         flush;
    string      name;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_uses_rs, id_uses_rt, ex_mem_read;
  logic branch_taken, jump, mem_busy, halt_req;

  exp_t q[$];
  bit   cur;
  int   checks;
  int   failures;

  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) a_if ();
  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(2))  b_if ();

  assign a_if.id_rs        = id_rs;
  assign a_if.id_rt        = id_rt;
  assign a_if.id_uses_rs   = id_uses_rs;
  assign a_if.id_uses_rt   = id_uses_rt;
  assign a_if.ex_mem_read  = ex_mem_read;
  assign a_if.ex_rd        = ex_rd;
  assign a_if.branch_taken = branch_taken;
  assign a_if.jump         = jump;
  assign a_if.mem_busy     = mem_busy;
  assign a_if.halt_req     = halt_req;

  assign b_if.id_rs        = id_rs;
  assign b_if.id_rt        = id_rt;
  assign b_if.id_uses_rs   = id_uses_rs;
  assign b_if.id_uses_rt   = id_uses_rt;
  assign b_if.ex_mem_read  = ex_mem_read;
  assign b_if.ex_rd        = ex_rd;
  assign b_if.branch_taken = branch_taken;
  assign b_if.jump         = jump;
  assign b_if.mem_busy     = mem_busy;
  assign b_if.halt_req     = halt_req;

  pipe_hazard_ctrl #(
    .REG_W(5), .INIT_CYCLES(2), .TIMEOUT(64), .CNT_W(16)
  ) u_a (
    .clk (clk),
    .rst (rst_a),
    .hz  (a_if)
  );

  pipe_hazard_ctrl #(
    .REG_W(5), .INIT_CYCLES(0), .TIMEOUT(4), .CNT_W(2)
  ) u_b (
    .clk (clk),
    .rst (rst_b),
    .hz  (b_if)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
  endtask

  task automatic cyc(input string nm, input logic [6:0] c,
                     input int s, input int f);
    exp_t e;
    e.sel = cur; e.ctrl = c; e.stall = s; e.flush = f; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    clr();
  endtask

  // Monitor: every cycle the DUT presents outputs, compare queued items.
  always @(negedge clk) begin
    exp_t e;
    logic [6:0]  ac;
    logic [31:0] as, af;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel == 1'b0) begin
        ac = {a_if.pc_write, a_if.if_id_write, a_if.if_id_flush,
              a_if.id_ex_bubble, a_if.pipe_freeze, a_if.halted,
              a_if.timeout_err};
        as = 32'(a_if.stall_cycles);
        af = 32'(a_if.flush_count);
      end else begin
        ac = {b_if.pc_write, b_if.if_id_write, b_if.if_id_flush,
              b_if.id_ex_bubble, b_if.pipe_freeze, b_if.halted,
              b_if.timeout_err};
        as = 32'(b_if.stall_cycles);
        af = 32'(b_if.flush_count);
      end
      checks++;
      if (ac !== e.ctrl || as !== 32'(e.stall) || af !== 32'(e.flush)) begin
        failures++;
        $display("FAIL %s: got ctrl=%b stall=%0d flush=%0d, want ctrl=%b stall=%0d flush=%0d",
                 e.name, ac, as, af, e.ctrl, e.stall, e.flush);
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    clr();
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Config A: INIT_CYCLES=2, TIMEOUT=64, CNT_W=16
    cur = 1'b0;
    cyc("a_in_reset", C_INIT, 0, 0);
    rst_a = 1'b0;
    cyc("a_init0", C_INIT, 0, 0);
    cyc("a_init1", C_INIT, 0, 0);
    cyc("a_run", C_RUN, 0, 0);
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    cyc("a_lu_rs", C_LU, 0, 0);
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    cyc("a_lu_rd0", C_RUN, 1, 0);
    ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1;
    cyc("a_lu_rt", C_LU, 1, 0);
    ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 0;
    cyc("a_lu_rt_unused", C_RUN, 2, 0);
    ex_mem_read = 1; ex_rd = 9; id_rs = 9; id_uses_rs = 1; branch_taken = 1;
    cyc("a_lu_br", C_LU, 2, 0);
    branch_taken = 1;
    cyc("a_br_after", C_FL, 3, 0);
    jump = 1;
    cyc("a_jump", C_FL, 3, 1);
    cyc("a_idle", C_RUN, 3, 2);
    mem_busy = 1;
    cyc("a_busy1", C_MB, 3, 2);
    mem_busy = 1;
    cyc("a_busy2", C_MB, 4, 2);
    mem_busy = 1; branch_taken = 1;
    cyc("a_busy3_br", C_MB, 5, 2);
    cyc("a_after_busy", C_RUN, 6, 2);
    mem_busy = 1;
    cyc("a_busyb1", C_MB, 6, 2);
    mem_busy = 1;
    cyc("a_busyb2", C_MB, 7, 2);
    mem_busy = 1; rst_a = 1'b1;
    cyc("a_rst_midwait", C_INIT, 0, 0);
    rst_a = 1'b0;
    cyc("a_reinit0", C_INIT, 0, 0);
    cyc("a_reinit1", C_INIT, 0, 0);
    cyc("a_rerun", C_RUN, 0, 0);
    halt_req = 1;
    cyc("a_halt_req", C_HR, 0, 0);
    cyc("a_halted", C_HLT, 0, 0);
    mem_busy = 1; branch_taken = 1;
    cyc("a_halt_stays", C_HLT, 0, 0);

    // Config B: INIT_CYCLES=0, TIMEOUT=4, CNT_W=2
    cur = 1'b1;
    cyc("b_in_reset", C_INIT, 0, 0);
    rst_b = 1'b0;
    cyc("b_init", C_INIT, 0, 0);
    for (int i = 0; i < 5; i++) begin
      jump = 1;
      cyc($sformatf("b_jump%0d", i), C_FL, 0, (i > 3) ? 3 : i);
    end
    cyc("b_flush_sat", C_RUN, 0, 3);
    for (int i = 0; i < 4; i++) begin
      mem_busy = 1;
      cyc($sformatf("b_busy%0d", i), C_MB, i, 3);
    end
    cyc("b_timeout", C_TMO, 3, 3);
    cyc("b_timeout_hold", C_TMO, 3, 3);
    rst_b = 1'b1;
    cyc("b_rst_halt", C_INIT, 0, 0);
    rst_b = 1'b0;
    cyc("b_reinit", C_INIT, 0, 0);
    halt_req = 1; mem_busy = 1;
    cyc("b_halt_over_busy", C_HR, 0, 0);
    cyc("b_halted", C_HLT, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
